// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking and sync decode, blanked
// pixel output, line interrupt, and a shadow timing register bank applied at frame wrap.
module video_timing_gen #(
   parameter int HW          = 9,
   parameter int VW          = 9,
   parameter int CW          = 12,
   parameter int H_TOTAL_M1  = 383,
   parameter int H_BLK_START = 290,
   parameter int H_SYN_START = 290,
   parameter int H_SYN_END   = 312,
   parameter int V_TOTAL_M1  = 262,
   parameter int V_BLK_START = 224,
   parameter int V_SYN_START = 227,
   parameter int V_SYN_END   = 234,
   parameter bit HS_ACT_LOW  = 1'b1,
   parameter bit VS_ACT_LOW  = 1'b1,
   parameter bit BLANK_COL0  = 1'b1
) (
   input  logic          PCLK,
   input  logic          RST_N,
   input  logic          CE,
   input  logic [CW-1:0] iRGB,
   input  logic          CFG_WE,
   input  logic [2:0]    CFG_SEL,
   input  logic [HW-1:0] CFG_DATA,
   input  logic          CFG_COMMIT,
   input  logic [VW-1:0] LINE_CMP,
   output logic [HW-1:0] HPOS,
   output logic [VW-1:0] VPOS,
   output logic          HBLK,
   output logic          VBLK,
   output logic          HSYN,
   output logic          VSYN,
   output logic [CW-1:0] oRGB,
   output logic          LINE_IRQ,
   output logic          CFG_PEND,
   output logic [15:0]   FRAME_CNT
);

   // Register bank index within each of the H and V groups.
   localparam int BLK = 0;
   localparam int SS  = 1;
   localparam int SE  = 2;
   localparam int TOT = 3;

   localparam logic [HW-1:0] RST_H [4] = '{HW'(H_BLK_START), HW'(H_SYN_START),
                                          HW'(H_SYN_END),   HW'(H_TOTAL_M1)};
   localparam logic [VW-1:0] RST_V [4] = '{VW'(V_BLK_START), VW'(V_SYN_START),
                                          VW'(V_SYN_END),   VW'(V_TOTAL_M1)};

   logic [HW-1:0] act_h [4];
   logic [HW-1:0] shd_h [4];
   logic [HW-1:0] nxt_h [4];
   logic [VW-1:0] act_v [4];
   logic [VW-1:0] shd_v [4];
   logic [VW-1:0] nxt_v [4];

   logic          h_wrap;
   logic          v_wrap;
   logic          f_wrap;
   logic          load;
   logic [HW-1:0] hpos_n;
   logic [VW-1:0] vpos_n;
   logic          hs_act;
   logic          vs_act;
   logic          pix_blank;
   logic          pend_n;

   function automatic logic in_win_h(input logic [HW-1:0] p, input logic [HW-1:0] s,
                                     input logic [HW-1:0] e);
      return (p >= s) && (p < e);
   endfunction

   function automatic logic in_win_v(input logic [VW-1:0] p, input logic [VW-1:0] s,
                                     input logic [VW-1:0] e);
      return (p >= s) && (p < e);
   endfunction

   always_comb begin
      h_wrap = (HPOS == act_h[TOT]);
      v_wrap = (VPOS == act_v[TOT]);
      f_wrap = h_wrap && v_wrap;
      load   = f_wrap && CFG_PEND;
      // Decode for the step into (0,0) must already see the freshly loaded timing.
      for (int i = 0; i < 4; i++) begin
         nxt_h[i] = load ? shd_h[i] : act_h[i];
         nxt_v[i] = load ? shd_v[i] : act_v[i];
      end
      hpos_n = h_wrap ? '0 : HPOS + HW'(1);
      if (!h_wrap)
         vpos_n = VPOS;
      else
         vpos_n = v_wrap ? '0 : VPOS + VW'(1);
      hs_act    = in_win_h(hpos_n, nxt_h[SS], nxt_h[SE]);
      vs_act    = in_win_v(vpos_n, nxt_v[SS], nxt_v[SE]);
      pix_blank = HBLK || VBLK || (BLANK_COL0 && (HPOS == '0));
      // A commit arriving with the wrap re-arms for the following frame.
      pend_n    = CFG_COMMIT || (CFG_PEND && !(CE && f_wrap));
   end

   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         HPOS      <= HW'(H_TOTAL_M1);
         VPOS      <= VW'(V_TOTAL_M1);
         HBLK      <= 1'b1;
         VBLK      <= 1'b1;
         HSYN      <= HS_ACT_LOW;
         VSYN      <= VS_ACT_LOW;
         oRGB      <= '0;
         LINE_IRQ  <= 1'b0;
         CFG_PEND  <= 1'b0;
         FRAME_CNT <= '0;
         for (int i = 0; i < 4; i++) begin
            act_h[i] <= RST_H[i];
            shd_h[i] <= RST_H[i];
            act_v[i] <= RST_V[i];
            shd_v[i] <= RST_V[i];
         end
      end else begin
         CFG_PEND <= pend_n;
         LINE_IRQ <= CE && h_wrap && (vpos_n == LINE_CMP);
         if (CFG_WE) begin
            if (CFG_SEL[2])
               shd_v[CFG_SEL[1:0]] <= VW'(CFG_DATA);
            else
               shd_h[CFG_SEL[1:0]] <= CFG_DATA;
         end
         if (CE) begin
            HPOS <= hpos_n;
            VPOS <= vpos_n;
            HBLK <= (hpos_n >= nxt_h[BLK]);
            VBLK <= (vpos_n >= nxt_v[BLK]);
            HSYN <= hs_act ^ HS_ACT_LOW;
            VSYN <= vs_act ^ VS_ACT_LOW;
            oRGB <= pix_blank ? '0 : iRGB;
            if (load) begin
               for (int i = 0; i < 4; i++) begin
                  act_h[i] <= shd_h[i];
                  act_v[i] <= shd_v[i];
               end
            end
            if (f_wrap)
               FRAME_CNT <= FRAME_CNT + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default raster, reprogrammed small raster,
// commit timing corner cases, CE gating and asynchronous reset.
module tb_video_timing_gen;

   logic        PCLK = 1'b0;
   logic        RST_N;
   logic        CE;
   logic [11:0] iRGB;
   logic        CFG_WE;
   logic [2:0]  CFG_SEL;
   logic [8:0]  CFG_DATA;
   logic        CFG_COMMIT;
   logic [8:0]  LINE_CMP;
   logic [8:0]  HPOS;
   logic [8:0]  VPOS;
   logic        HBLK;
   logic        VBLK;
   logic        HSYN;
   logic        VSYN;
   logic [11:0] oRGB;
   logic        LINE_IRQ;
   logic        CFG_PEND;
   logic [15:0] FRAME_CNT;

   int checks = 0;
   int errors = 0;

   video_timing_gen dut (
      .PCLK(PCLK), .RST_N(RST_N), .CE(CE), .iRGB(iRGB),
      .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_DATA(CFG_DATA), .CFG_COMMIT(CFG_COMMIT),
      .LINE_CMP(LINE_CMP), .HPOS(HPOS), .VPOS(VPOS), .HBLK(HBLK), .VBLK(VBLK),
      .HSYN(HSYN), .VSYN(VSYN), .oRGB(oRGB), .LINE_IRQ(LINE_IRQ),
      .CFG_PEND(CFG_PEND), .FRAME_CNT(FRAME_CNT)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge PCLK);
   endtask

   task automatic adv_until(input logic [8:0] h, input logic [8:0] v, input int budget,
                            output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(HPOS == h && VPOS == v) && n < budget);
   endtask

   task automatic run_until_h0(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (HPOS != 9'd0 && n < budget);
   endtask

   initial begin
      int n, hs, vs, hb, vb, irqs, irq_h, irq_v, prev;
      int cfg [8];
      cfg = '{20, 22, 25, 29, 6, 7, 9, 10};

      RST_N = 1'b0; CE = 1'b0; iRGB = 12'h000; CFG_WE = 1'b0; CFG_SEL = 3'd0;
      CFG_DATA = 9'd0; CFG_COMMIT = 1'b0; LINE_CMP = 9'd5;
      tick();
      chk("rst_hpos", 32'(HPOS), 383);
      chk("rst_vpos", 32'(VPOS), 262);
      chk("rst_hblk", 32'(HBLK), 1);
      chk("rst_vblk", 32'(VBLK), 1);
      chk("rst_hsyn", 32'(HSYN), 1);
      chk("rst_vsyn", 32'(VSYN), 1);
      chk("rst_orgb", 32'(oRGB), 0);
      chk("rst_irq", 32'(LINE_IRQ), 0);
      chk("rst_pend", 32'(CFG_PEND), 0);
      chk("rst_fcnt", 32'(FRAME_CNT), 0);

      // Default raster, first CE is the frame wrap
      RST_N = 1'b1; CE = 1'b1; iRGB = 12'hFFF;
      tick();
      chk("wrap_hpos", 32'(HPOS), 0);
      chk("wrap_vpos", 32'(VPOS), 0);
      chk("wrap_fcnt", 32'(FRAME_CNT), 1);
      chk("wrap_hblk", 32'(HBLK), 0);
      chk("wrap_vblk", 32'(VBLK), 0);
      chk("wrap_orgb", 32'(oRGB), 0);
      tick();
      chk("col0_orgb", 32'(oRGB), 0);
      tick();
      chk("col1_orgb", 32'(oRGB), 12'hFFF);
      adv_until(9'd289, 9'd0, 2000, n);
      chk("to289_n", 32'(n), 287);
      chk("h289_hblk", 32'(HBLK), 0);
      chk("h289_hsyn", 32'(HSYN), 1);
      chk("h289_orgb", 32'(oRGB), 12'hFFF);
      n = 0; hs = 0; hb = 0;
      do begin
         tick();
         n++;
         if (!HSYN) hs++;
         if (HBLK) hb++;
      end while (HPOS != 9'd0 && n < 2000);
      chk("line_tail_n", 32'(n), 95);
      chk("hsync_len", 32'(hs), 22);
      chk("hblank_len", 32'(hb), 94);
      chk("line1_vpos", 32'(VPOS), 1);
      chk("line1_vsyn", 32'(VSYN), 1);
      chk("line1_vblk", 32'(VBLK), 0);
      tick();
      chk("l1_col0_orgb", 32'(oRGB), 0);
      tick();
      chk("l1_col1_orgb", 32'(oRGB), 12'hFFF);

      // CE gating
      CE = 1'b0; iRGB = 12'h123;
      repeat (3) tick();
      chk("ce0_hpos", 32'(HPOS), 2);
      chk("ce0_orgb", 32'(oRGB), 12'hFFF);
      chk("ce0_irq", 32'(LINE_IRQ), 0);
      for (int i = 0; i < 10; i++) begin
         prev = int'(HPOS);
         CE = (i % 2 == 0);
         tick();
         if (!CE) chk("ce_toggle_hold", 32'(HPOS), 32'(prev));
      end
      chk("ce_toggle_hpos", 32'(HPOS), 7);
      chk("ce_toggle_orgb", 32'(oRGB), 12'h123);

      // Small raster programmed while CE is held low after reset
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1; CE = 1'b0; iRGB = 12'hFFF;
      for (int i = 0; i < 8; i++) begin
         CFG_WE = 1'b1; CFG_SEL = 3'(i); CFG_DATA = 9'(cfg[i]);
         tick();
      end
      CFG_WE = 1'b0; CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
      chk("prog_pend", 32'(CFG_PEND), 1);
      chk("prog_hpos_held", 32'(HPOS), 383);
      CE = 1'b1;
      tick();
      chk("small_wrap_pend", 32'(CFG_PEND), 0);
      chk("small_wrap_fcnt", 32'(FRAME_CNT), 1);
      chk("small_wrap_hsyn", 32'(HSYN), 1);
      n = 0; hs = 0; vs = 0; hb = 0; vb = 0; irqs = 0; irq_h = -1; irq_v = -1;
      do begin
         tick();
         n++;
         if (!HSYN) hs++;
         if (!VSYN) vs++;
         if (HBLK) hb++;
         if (VBLK) vb++;
         if (LINE_IRQ) begin irqs++; irq_h = int'(HPOS); irq_v = int'(VPOS); end
      end while (!(HPOS == 9'd0 && VPOS == 9'd0) && n < 2000);
      chk("small_frame_len", 32'(n), 330);
      chk("small_hsync", 32'(hs), 33);
      chk("small_vsync", 32'(vs), 60);
      chk("small_hblank", 32'(hb), 110);
      chk("small_vblank", 32'(vb), 150);
      chk("irq_count", 32'(irqs), 1);
      chk("irq_hpos", 32'(irq_h), 0);
      chk("irq_vpos", 32'(irq_v), 5);
      chk("small_fcnt", 32'(FRAME_CNT), 2);
      LINE_CMP = 9'd300;
      n = 0; irqs = 0;
      do begin
         tick();
         n++;
         if (LINE_IRQ) irqs++;
      end while (!(HPOS == 9'd0 && VPOS == 9'd0) && n < 2000);
      chk("irq300_len", 32'(n), 330);
      chk("irq300_count", 32'(irqs), 0);

      // Mid-frame write and commit takes effect only at the next wrap
      adv_until(9'd15, 9'd1, 2000, n);
      chk("mid_n", 32'(n), 45);
      CFG_WE = 1'b1; CFG_SEL = 3'd3; CFG_DATA = 9'd19;
      tick();
      CFG_WE = 1'b0; CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
      chk("mid_pend", 32'(CFG_PEND), 1);
      run_until_h0(2000, n);
      chk("mid_line_old", 32'(n), 13);
      adv_until(9'd0, 9'd0, 2000, n);
      chk("mid_to_wrap", 32'(n), 270);
      chk("mid_wrap_pend", 32'(CFG_PEND), 0);
      run_until_h0(2000, n);
      chk("mid_line_new", 32'(n), 20);

      // Write and commit landing on the same clock as a pending wrap
      CFG_WE = 1'b1; CFG_SEL = 3'd0; CFG_DATA = 9'd0;
      tick();
      CFG_WE = 1'b0; CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
      chk("same_pre_pend", 32'(CFG_PEND), 1);
      adv_until(9'd19, 9'd10, 2000, n);
      chk("same_at_end_h", 32'(HPOS), 19);
      CFG_WE = 1'b1; CFG_SEL = 3'd3; CFG_DATA = 9'd39; CFG_COMMIT = 1'b1;
      tick();
      CFG_WE = 1'b0; CFG_COMMIT = 1'b0;
      chk("same_hpos", 32'(HPOS), 0);
      chk("same_vpos", 32'(VPOS), 0);
      chk("same_pend", 32'(CFG_PEND), 1);
      chk("same_new_hblk", 32'(HBLK), 1);
      chk("same_fcnt", 32'(FRAME_CNT), 5);
      run_until_h0(2000, n);
      chk("same_line_old_shadow", 32'(n), 20);
      adv_until(9'd0, 9'd0, 2000, n);
      chk("same_to_wrap", 32'(n), 200);
      chk("same_wrap2_pend", 32'(CFG_PEND), 0);
      run_until_h0(2000, n);
      chk("same_line_written", 32'(n), 40);

      // Asynchronous reset mid-frame with a pending commit
      CFG_WE = 1'b1; CFG_SEL = 3'd7; CFG_DATA = 9'd3;
      tick();
      CFG_WE = 1'b0; CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
      repeat (5) tick();
      chk("pre_rst_pend", 32'(CFG_PEND), 1);
      RST_N = 1'b0;
      #1;
      chk("arst_hpos", 32'(HPOS), 383);
      chk("arst_vpos", 32'(VPOS), 262);
      chk("arst_pend", 32'(CFG_PEND), 0);
      chk("arst_fcnt", 32'(FRAME_CNT), 0);
      chk("arst_hblk", 32'(HBLK), 1);
      chk("arst_vsyn", 32'(VSYN), 1);
      chk("arst_orgb", 32'(oRGB), 0);
      tick();
      CE = 1'b0; RST_N = 1'b1;
      CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
      CE = 1'b1;
      tick();
      chk("post_rst_hpos", 32'(HPOS), 0);
      chk("post_rst_pend", 32'(CFG_PEND), 0);
      chk("post_rst_fcnt", 32'(FRAME_CNT), 1);
      chk("post_rst_hblk", 32'(HBLK), 0);
      run_until_h0(2000, n);
      chk("post_rst_line", 32'(n), 384);
      chk("post_rst_vpos", 32'(VPOS), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- HW, 9, horizontal counter width
- VW, 9, vertical counter width
- CW, 12, pixel colour width
- H_TOTAL_M1, 383, last horizontal count
- H_BLK_START, 290, first horizontally blanked count
- H_SYN_START, 290, first hsync count
- H_SYN_END, 312, first count after hsync
- V_TOTAL_M1, 262, last line
- V_BLK_START, 224, first vertically blanked line
- V_SYN_START, 227, first vsync line
- V_SYN_END, 234, first line after vsync
- HS_ACT_LOW, 1, hsync active level is 0 when 1
- VS_ACT_LOW, 1, vsync active level is 0 when 1
- BLANK_COL0, 1, force colour 0 at HPOS==0 when 1

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- PCLK, in, 1, pixel clock, rising edge
- RST_N, in, 1, reset, asynchronous, active-low
- CE, in, 1, pixel enable; all state advances only when 1
- iRGB, in, CW, input pixel
- CFG_WE, in, 1, shadow register write strobe
- CFG_SEL, in, 3, register select: 0 H_BLK_START, 1 H_SYN_START, 2 H_SYN_END, 3 H_TOTAL_M1, 4 V_BLK_START, 5 V_SYN_START, 6 V_SYN_END, 7 V_TOTAL_M1
- CFG_DATA, in, HW, write data; V registers take low VW bits
- CFG_COMMIT, in, 1, request shadow-to-active copy at next frame wrap
- LINE_CMP, in, VW, line-interrupt compare value
- HPOS, out, HW, horizontal counter
- VPOS, out, VW, vertical counter
- HBLK, VBLK, out, 1 each, blanking, active-high
- HSYN, VSYN, out, 1 each, sync at polarity per HS/VS_ACT_LOW
- oRGB, out, CW, blanked pixel output, registered
- LINE_IRQ, out, 1, one-CE pulse at start of compared line
- CFG_PEND, out, 1, commit pending
- FRAME_CNT, out, 16, frame counter

Function
REQ-003 Active timing registers SHALL reset to the parameter values; shadow registers SHALL reset to the same values.
REQ-004 On CE: HPOS SHALL increment; at HPOS==H_TOTAL_M1 it SHALL wrap to 0 and VPOS SHALL increment, wrapping to 0 after V_TOTAL_M1.
REQ-005 Frame wrap SHALL be the CE step from (H_TOTAL_M1, V_TOTAL_M1) to (0,0).
REQ-006 HBLK, VBLK, HSYN, VSYN SHALL be registered and aligned with HPOS/VPOS: HBLK=1 iff HPOS>=H_BLK_START; VBLK=1 iff VPOS>=V_BLK_START; hsync active iff H_SYN_START<=HPOS<H_SYN_END; vsync active iff V_SYN_START<=VPOS<V_SYN_END; START>=END SHALL yield no sync.
REQ-007 oRGB SHALL be loaded on each CE with 0 if HBLK|VBLK|(BLANK_COL0 & HPOS==0) for the current position, else iRGB; one CE of latency.
REQ-008 CFG_WE SHALL write CFG_DATA into shadow[CFG_SEL] on any clock, regardless of CE; active registers SHALL be unaffected.
REQ-009 CFG_COMMIT SHALL set CFG_PEND; on frame wrap with CFG_PEND=1 all eight active registers SHALL load from shadow atomically, and CFG_PEND SHALL clear.
REQ-010 Same-cycle write and wrap: the copy SHALL use shadow contents before the write; the write SHALL land in shadow only.
REQ-011 Same-cycle commit and wrap-with-pending: copy SHALL occur and CFG_PEND SHALL remain 1.
REQ-012 Timing decode on the CE step into (0,0) SHALL use the newly loaded values.
REQ-013 LINE_IRQ SHALL be 1 for exactly the CE step where HPOS becomes 0 and VPOS becomes LINE_CMP, else 0; LINE_CMP>V_TOTAL_M1 SHALL never fire.
REQ-014 FRAME_CNT SHALL increment by 1 on each frame wrap, wrapping modulo 2^16.
REQ-015 CE=0 SHALL hold all counters and outputs; LINE_IRQ SHALL hold 0.

Reset
REQ-016 RST_N=0 SHALL asynchronously set HPOS=H_TOTAL_M1, VPOS=V_TOTAL_M1, HBLK=1, VBLK=1, HSYN/VSYN inactive level, oRGB=0, LINE_IRQ=0, CFG_PEND=0, FRAME_CNT=0, and registers per REQ-003.
REQ-017 First CE after release SHALL be a frame wrap: HPOS=0, VPOS=0, FRAME_CNT=1, HBLK=0, VBLK=0.
REQ-018 Reset mid-frame SHALL discard pending commit but SHALL also reset shadow registers.

Verification
REQ-019 Defaults, CE=1 constant -> HSYN=0 for HPOS 290..311 (22 clocks), HBLK=1 for 290..383, VSYN=0 on lines 227..233, 384x263 clocks per frame.
REQ-020 iRGB=12'hFFF constant -> oRGB=12'hFFF one clock after HPOS 1..289 on lines 0..223, 0 otherwise incl. HPOS 0.
REQ-021 Write H_TOTAL_M1=99 then commit mid-frame -> current frame unchanged; next frame lines are 100 clocks; CFG_PEND clears at wrap.
REQ-022 CE toggling 1/0 -> counters advance once per two clocks; outputs stable on CE=0 clocks.
REQ-023 LINE_CMP=5 -> LINE_IRQ single pulse when (HPOS,VPOS) becomes (0,5), once per frame; LINE_CMP=300 -> none.
REQ-024 RST_N asserted at HPOS=150 line 100 with pending commit -> immediate reset values, CFG_PEND=0, defaults timing after release.
